// File: rtl/conv_result_writer.sv
// conv_result_writer
//   Sink end of the convolution result stream. Packs RESULT_DWIDTH-bit beats
//   little-endian into MEM_DWIDTH-bit words and writes them to consecutive
//   word addresses from a programmable base. The final partial word is
//   zero-padded. done pulses once the final write has been accepted.
//
//   Optional feature: define RESULT_WR_STROBE_EN to add mem_be, a per-lane
//   byte-enable marking which lanes of the written word hold real results.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   start, base_addr, num_results job launch (accepted only when idle)
//   result_data, result_valid     result beats, no back-pressure
//   accum_ovrflow                 datapath overflow flag (sticky-captured)
//   mem_addr, mem_wdata, mem_we   write request, held until mem_ready
//   mem_be                        lane strobes (RESULT_WR_STROBE_EN only)
//   mem_ready                     write accepted on mem_we & mem_ready
//   busy, done                    job in progress / 1-cycle end pulse
//   err_ovrflow, overrun          sticky job status flags
module conv_result_writer #(
  parameter int RESULT_DWIDTH = 8,
  parameter int MEM_DWIDTH    = 24,
  parameter int ADDR_WIDTH    = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [CNT_WIDTH-1:0]     num_results,
  input  logic [RESULT_DWIDTH-1:0] result_data,
  input  logic                     result_valid,
  input  logic                     accum_ovrflow,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [MEM_DWIDTH-1:0]    mem_wdata,
  output logic                     mem_we,
`ifdef RESULT_WR_STROBE_EN
  output logic [MEM_DWIDTH/RESULT_DWIDTH-1:0] mem_be,
`endif
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err_ovrflow,
  output logic                     overrun
);

  localparam int LANES = MEM_DWIDTH / RESULT_DWIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                 state, state_nx;
  logic [CNT_WIDTH-1:0]   num_q, res_cnt;
  logic [LW-1:0]          lane_cnt;
  logic [MEM_DWIDTH-1:0]  pack_q, full_word;

  logic accept, hold_free, beat, word_full, last_beat, pad_move;

  // Holding register is mem_wdata/mem_we themselves; it can take a new word
  // when empty or when its current word is being accepted this cycle.
  assign accept    = mem_we & mem_ready;
  assign hold_free = ~mem_we | mem_ready;
  assign beat      = (state == RUN) & result_valid;
  assign word_full = beat & (lane_cnt == LW'(LANES - 1));
  assign last_beat = beat & ((res_cnt + CNT_WIDTH'(1)) == num_q);
  assign pad_move  = (state == FLUSH) & (lane_cnt != '0) & hold_free;

  assign busy = (state == RUN) | (state == FLUSH);
  assign done = (state == DONE);

  // Word completed by the current beat; lanes not yet written are zero
  // because the pack register is cleared whenever a word leaves it.
  always_comb begin
    full_word = pack_q;
    full_word[(LANES-1)*RESULT_DWIDTH +: RESULT_DWIDTH] = result_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (num_results == '0) ? DONE : RUN;
      RUN:     if (last_beat) state_nx = FLUSH;
      // Leave as soon as the last write is accepted so done follows it by one cycle.
      FLUSH:   if ((lane_cnt == '0) && hold_free) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      num_q       <= '0;
      res_cnt     <= '0;
      lane_cnt    <= '0;
      pack_q      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      err_ovrflow <= 1'b0;
      overrun     <= 1'b0;
`ifdef RESULT_WR_STROBE_EN
      mem_be      <= '0;
`endif
    end else begin
      state <= state_nx;

      if ((state == IDLE) && start) begin
        num_q       <= num_results;
        mem_addr    <= base_addr;
        res_cnt     <= '0;
        lane_cnt    <= '0;
        pack_q      <= '0;
        err_ovrflow <= 1'b0;
        overrun     <= 1'b0;
      end

      if (busy && accum_ovrflow) err_ovrflow <= 1'b1;

      if (beat) begin
        res_cnt <= res_cnt + CNT_WIDTH'(1);
        if (word_full) begin
          lane_cnt <= '0;
          pack_q   <= '0;
        end else begin
          lane_cnt <= lane_cnt + LW'(1);
          pack_q[lane_cnt*RESULT_DWIDTH +: RESULT_DWIDTH] <= result_data;
        end
      end

      if (pad_move) begin
        lane_cnt <= '0;
        pack_q   <= '0;
      end

      // Address wraps naturally at 2^ADDR_WIDTH.
      if (accept) mem_addr <= mem_addr + ADDR_WIDTH'(1);

      if ((word_full && hold_free) || pad_move) begin
        mem_wdata <= word_full ? full_word : pack_q;
        mem_we    <= 1'b1;
`ifdef RESULT_WR_STROBE_EN
        mem_be    <= word_full ? {LANES{1'b1}} : LANES'((1 << lane_cnt) - 1);
`endif
      end else begin
        if (accept) mem_we <= 1'b0;
        if (word_full) overrun <= 1'b1;  // holding reg still occupied: word lost
      end
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
module tb_conv_result_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_results = '0;
  logic [7:0]  result_data = '0;
  logic        result_valid = 1'b0;
  logic        accum_ovrflow = 1'b0;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        busy, done, err_ovrflow, overrun;
`ifdef RESULT_WR_STROBE_EN
  logic [2:0]  mem_be;
`endif

  conv_result_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_results(num_results), .result_data(result_data), .result_valid(result_valid),
    .accum_ovrflow(accum_ovrflow), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we),
`ifdef RESULT_WR_STROBE_EN
    .mem_be(mem_be),
`endif
    .mem_ready(mem_ready), .busy(busy), .done(done),
    .err_ovrflow(err_ovrflow), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [23:0] d;
    logic [2:0]  be;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] beats[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, last_wr_cyc = 0;
  int done_seen = 0, n_wr = 0, stab_err = 0;
  bit timeout = 0;
  bit prev_stall = 0;
  logic [39:0] prev_aw = '0;

  // Scoreboard: every accepted write is compared against the model's queue.
  always @(negedge clk) begin
    cyc++;
    if (start) start_cyc = cyc;
    if (mem_we && mem_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== {e.a, e.d}) begin
          n_fail++;
          $display("FAIL write addr/data got=%h/%h exp=%h/%h", mem_addr, mem_wdata, e.a, e.d);
        end
`ifdef RESULT_WR_STROBE_EN
        n_checks++;
        if (mem_be !== e.be) begin
          n_fail++;
          $display("FAIL write_be got=%b exp=%b", mem_be, e.be);
        end
`endif
      end
      last_wr_cyc = cyc;
      n_wr++;
    end
    if (reset_n && prev_stall && (!mem_we || {mem_addr, mem_wdata} !== prev_aw)) stab_err++;
    prev_stall = reset_n && mem_we && !mem_ready;
    prev_aw    = {mem_addr, mem_wdata};
    if (done) begin done_seen++; done_cyc = cyc; end
  end

  // Reference: word w holds beats 3w..3w+2 little-endian, zero padded,
  // written at base+w modulo 2^16. keep limits how many words survive.
  task automatic model_job(input logic [15:0] base, input int keep);
    int n = beats.size();
    int nw = (n + 2) / 3;
    exp_q.delete();
    for (int w = 0; w < nw && w < keep; w++) begin
      wr_t e;
      e.a = base + 16'(w); e.d = '0; e.be = '0;
      for (int k = 0; k < 3; k++)
        if (w * 3 + k < n) begin
          e.d[k*8 +: 8] = beats[w*3+k];
          e.be[k] = 1'b1;
        end
      exp_q.push_back(e);
    end
  endtask

  // rmode: 0 ready always, 1 random ready with single-cycle stalls, 2 ready from cycle 'stall'
  task automatic drive_job(input logic [15:0] base, input int gmin, input int gmax,
                           input int rmode, input int stall, input bit ovf);
    int i = 0, gap = 0, t = 0, d0;
    bit pr = 1;
    @(posedge clk); #1;
    base_addr = base; num_results = 16'(beats.size()); start = 1;
    @(posedge clk); #1;
    start = 0; d0 = done_seen; timeout = 0;
    while (done_seen == d0) begin
      if (t >= 600) begin timeout = 1; break; end
      case (rmode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = pr ? 1'($urandom_range(0, 1)) : 1'b1;
        default: mem_ready = (t >= stall);
      endcase
      pr = mem_ready;
      if (i < beats.size() && gap == 0) begin
        result_valid = 1; result_data = beats[i]; i++;
        gap = $urandom_range(gmin, gmax);
      end else begin
        result_valid = 0;
        if (gap > 0) gap--;
      end
      accum_ovrflow = ovf && (t == 1);
      @(posedge clk); #1; t++;
    end
    result_valid = 0; accum_ovrflow = 0; mem_ready = 1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_addr, mem_wdata, mem_we, busy, done, err_ovrflow, overrun} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0",
               {mem_addr, mem_wdata, mem_we, busy, done, err_ovrflow, overrun});
    end
    reset_n = 1;
  endtask

  task automatic test_directed;
    beats.delete();
    for (int i = 1; i <= 6; i++) beats.push_back(8'(i));
    model_job(16'h0010, 99);
    n_checks++;
    if (exp_q[0].d !== 24'h030201 || exp_q[1].d !== 24'h060504) begin
      n_fail++; $display("FAIL directed_model got=%h,%h exp=030201,060504", exp_q[0].d, exp_q[1].d);
    end
    drive_job(16'h0010, 0, 0, 0, 0, 0);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL directed_timeout got=1 exp=0"); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL directed_missing got=%0d exp=0", exp_q.size()); end
    n_checks++;
    if (done_cyc - last_wr_cyc !== 1) begin
      n_fail++; $display("FAIL directed_done_lat got=%0d exp=1", done_cyc - last_wr_cyc);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL directed_busy got=%b exp=0", busy); end
  endtask

  task automatic test_pad;
    beats.delete();
    beats.push_back(8'hAA); beats.push_back(8'hBB); beats.push_back(8'hCC); beats.push_back(8'hDD);
    model_job(16'h0100, 99);
    drive_job(16'h0100, 0, 2, 0, 0, 0);
    n_checks++;
    if (timeout !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL pad_writes timeout=%b left=%0d exp=0,0", timeout, exp_q.size());
    end
    n_checks++;
    if (done_cyc - last_wr_cyc !== 1) begin
      n_fail++; $display("FAIL pad_done_lat got=%0d exp=1", done_cyc - last_wr_cyc);
    end
  endtask

  task automatic test_stall;
    beats.delete();
    for (int i = 0; i < 9; i++) beats.push_back(8'($urandom));
    model_job(16'h2000, 99);
    drive_job(16'h2000, 1, 1, 2, 10, 0);
    n_checks++;
    if (timeout !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL stall_writes timeout=%b left=%0d exp=0,0", timeout, exp_q.size());
    end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL stall_overrun got=%b exp=0", overrun); end
    n_checks++;
    if (stab_err !== 0) begin n_fail++; $display("FAIL stall_hold_stable got=%0d exp=0", stab_err); end
  endtask

  task automatic test_overrun;
    beats.delete();
    for (int i = 0; i < 9; i++) beats.push_back(8'($urandom));
    model_job(16'h3000, 1);  // words 2 and 3 complete while word 1 waits
    drive_job(16'h3000, 0, 0, 2, 30, 0);
    n_checks++;
    if (timeout !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL overrun_writes timeout=%b left=%0d exp=0,0", timeout, exp_q.size());
    end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
  endtask

  task automatic test_wrap;
    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back(8'($urandom));
    model_job(16'hFFFF, 99);
    drive_job(16'hFFFF, 0, 1, 0, 0, 0);
    n_checks++;
    if (timeout !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL wrap_writes timeout=%b left=%0d exp=0,0", timeout, exp_q.size());
    end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL wrap_overrun_cleared got=%b exp=0", overrun); end
  endtask

  task automatic test_err;
    beats.delete();
    for (int i = 0; i < 5; i++) beats.push_back(8'($urandom));
    model_job(16'h4000, 99);
    drive_job(16'h4000, 0, 1, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (err_ovrflow !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", err_ovrflow); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL err_writes left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_zero;
    int w0 = n_wr;
    beats.delete();
    exp_q.delete();
    drive_job(16'h5000, 0, 0, 0, 0, 0);
    n_checks++;
    if (done_cyc - start_cyc !== 1) begin
      n_fail++; $display("FAIL zero_done_lat got=%0d exp=1", done_cyc - start_cyc);
    end
    n_checks++;
    if (n_wr !== w0) begin n_fail++; $display("FAIL zero_no_write got=%0d exp=%0d", n_wr, w0); end
    n_checks++;
    if (err_ovrflow !== 1'b0) begin n_fail++; $display("FAIL zero_err_cleared got=%b exp=0", err_ovrflow); end
  endtask

  task automatic test_random;
    for (int j = 0; j < 8; j++) begin
      logic [15:0] base = 16'($urandom);
      int n = $urandom_range(1, 20);
      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back(8'($urandom));
      model_job(base, 99);
      drive_job(base, 0, 3, 1, 0, 0);
      n_checks++;
      if (timeout !== 1'b0 || exp_q.size() !== 0) begin
        n_fail++; $display("FAIL random%0d_writes timeout=%b left=%0d exp=0,0", j, timeout, exp_q.size());
      end
      n_checks++;
      if (done_cyc - last_wr_cyc !== 1) begin
        n_fail++; $display("FAIL random%0d_done_lat got=%0d exp=1", j, done_cyc - last_wr_cyc);
      end
      n_checks++;
      if ({overrun, err_ovrflow} !== 2'b00) begin
        n_fail++; $display("FAIL random%0d_flags got=%b exp=00", j, {overrun, err_ovrflow});
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int w0;
    exp_q.delete();
    @(posedge clk); #1;
    base_addr = 16'h0020; num_results = 16'd6; start = 1; mem_ready = 0;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 3; i++) begin
      result_valid = 1; result_data = 8'($urandom);
      @(posedge clk); #1;
    end
    result_valid = 0;
    n_checks++;
    if ({mem_we, busy} !== 2'b11) begin
      n_fail++; $display("FAIL midrun_pre got=%b exp=11", {mem_we, busy});
    end
    #2 reset_n = 0;
    #1;
    n_checks++;
    if ({mem_addr, mem_wdata, mem_we, busy, done, err_ovrflow, overrun} !== 45'd0) begin
      n_fail++;
      $display("FAIL midrun_reset got=%h exp=0",
               {mem_addr, mem_wdata, mem_we, busy, done, err_ovrflow, overrun});
    end
    mem_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    w0 = n_wr;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (n_wr !== w0 || mem_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_after writes=%0d we=%b busy=%b exp=%0d,0,0", n_wr, mem_we, busy, w0);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_pad;
    test_stall;
    test_overrun;
    test_wrap;
    test_err;
    test_zero;
    test_random;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
